// File: rtl/tp_mem_wr_packer.sv
// Packs a narrow valid/ready beat stream into full memory words and issues one write per word
// at auto-incrementing addresses. Optional early-flush support is enabled by TPM_PACK_FLUSH_EN.
module tp_mem_wr_packer #(
  parameter int IN_W   = 64,
  parameter int WORD_W = 4096,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len_words,
  input  logic              s_valid,
  input  logic [IN_W-1:0]   s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_word,
  output logic              busy,
  output logic              done
`ifdef TPM_PACK_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  localparam int BEATS = WORD_W / IN_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W:0]   r_left;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_pack;
  logic [WORD_W-1:0] r_word;

  logic              w_accept;
  logic              w_last;
  logic              w_flush_go;
  logic              w_to_write;
  logic [WORD_W-1:0] w_pack_next;

  // Jobs longer than the memory depth are clamped to one full pass.
  function automatic logic [ADDR_W:0] f_sat_len(input logic [ADDR_W:0] len);
    return (len > MAX_WORDS) ? MAX_WORDS : len;
  endfunction

  assign w_accept = (r_state == S_FILL) && s_valid;
  assign w_last   = w_accept && (r_cnt == CNT_W'(BEATS - 1));

`ifdef TPM_PACK_FLUSH_EN
  assign w_flush_go = (r_state == S_FILL) && flush && ((r_cnt != '0) || w_accept);
`else
  assign w_flush_go = 1'b0;
`endif

  assign w_to_write = w_last || w_flush_go;

  always_comb begin
    w_pack_next = r_pack;
    if (w_accept) begin
      w_pack_next[int'(r_cnt) * IN_W +: IN_W] = s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_left  <= '0;
      r_addr  <= '0;
      r_pack  <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= base_addr;
            r_left  <= f_sat_len(len_words);
            r_cnt   <= '0;
            r_pack  <= '0;
            r_state <= (len_words == '0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          // The pack register is cleared on hand-off so a flushed word carries zero lanes.
          if (w_to_write) begin
            r_word  <= w_pack_next;
            r_pack  <= '0;
            r_cnt   <= '0;
            r_state <= S_WRITE;
          end else if (w_accept) begin
            r_pack <= w_pack_next;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_left  <= r_left - 1'b1;
          r_state <= (r_left == {{ADDR_W{1'b0}}, 1'b1}) ? S_DONE : S_FILL;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_ready = (r_state == S_FILL);
  assign wr_en   = (r_state == S_WRITE);
  assign busy    = (r_state == S_FILL) || (r_state == S_WRITE);
  assign done    = (r_state == S_DONE);
  assign wr_addr = r_addr;
  assign wr_word = r_word;

endmodule
